wb_dbg_master: RTL and testbench
================================

WB_DBG_MASTER -- requirements
Module: wb_dbg_master

Interface
REQ-001 SHALL have parameter timeout_cycles, default 1024, meaning bus cycles to wait for ack/err before abort (range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_data  input  8  command byte from serial receiver.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid.
REQ-006 SHALL have port rx_ready  output  1  byte accepted when rx_valid&rx_ready at clk edge.
REQ-007 SHALL have port tx_data  output  8  response byte to serial transmitter.
REQ-008 SHALL have port tx_valid  output  1  tx_data valid.
REQ-009 SHALL have port tx_ready  input  1  byte consumed when tx_valid&tx_ready at clk edge.
REQ-010 SHALL have ports wb_adr_o out 32, wb_dat_o out 32, wb_dat_i in 32, wb_sel_o out 4, wb_we_o out 1, wb_cyc_o out 1, wb_stb_o out 1, wb_ack_i in 1, wb_err_i in 1: Wishbone classic initiator.
REQ-011 SHALL use one clock; reset asynchronous, active-low.

Function
REQ-012 SHALL implement states IDLE, ADDR, DATA, BUS, RESP, SEND.
REQ-013 IDLE: rx_ready=1; byte 0x57 ('W') -> ADDR, write pending; 0x52 ('R') -> ADDR, read pending; any other byte discarded, stay IDLE.
REQ-014 ADDR: rx_ready=1; accept 4 bytes MSB first into address register; after 4th: write -> DATA, read -> BUS.
REQ-015 DATA: rx_ready=1; accept 4 bytes MSB first into write data register; after 4th -> BUS.
REQ-016 rx_ready SHALL be 0 in BUS, RESP, SEND; no byte is consumed there.
REQ-017 BUS: wb_cyc_o=wb_stb_o=1 starting the cycle after the last command byte is accepted; wb_sel_o=4'hF; wb_we_o=1 for write, 0 for read; wb_adr_o, wb_dat_o held stable for whole cycle.
REQ-018 On edge with wb_ack_i=1 and wb_err_i=0: capture wb_dat_i (read), status=0x00; wb_cyc_o/wb_stb_o deassert next cycle; -> RESP.
REQ-019 On edge with wb_err_i=1 (err wins over simultaneous ack): status=0x01, read data not captured; -> RESP.
REQ-020 16-bit timeout counter cleared on BUS entry, increments each BUS cycle; on reaching timeout_cycles without ack/err: deassert cyc/stb, status=0x02, -> RESP. Ack on the same edge as timeout wins.
REQ-021 RESP: tx_valid=1, tx_data=status; held stable until tx_ready; then read with status 0x00 -> SEND, else -> IDLE.
REQ-022 SEND: transmit captured read data 4 bytes MSB first, each held until tx_ready; after 4th -> IDLE.
REQ-023 tx_valid SHALL be 0 outside RESP and SEND; wb_cyc_o/wb_stb_o SHALL be 0 outside BUS.
REQ-024 Byte counter 2-bit, wraps 3->0 at each phase end; no other arithmetic beyond timeout counter.
REQ-025 Latency: minimum write transaction = 9 accepted bytes + 1 idle-to-stb cycle + ack + 1 cycle to status valid.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, tx_valid=0, tx_data=0, rx_ready=0, counters and status 0.
REQ-027 rx_ready SHALL rise the first cycle after rst_n deasserts.
REQ-028 Reset during BUS SHALL drop cyc/stb asynchronously; no response byte is emitted afterwards.

Verification
REQ-029 Write: bytes 57 00 00 00 10 DE AD BE EF, slave acks after 3 cycles -> one WB cycle adr=0x00000010, dat=0xDEADBEEF, we=1, sel=F; tx byte 0x00 only.
REQ-030 Read: bytes 52 F0 00 00 04, slave returns 0x12345678 with ack -> tx bytes 00 12 34 56 78, we=0.
REQ-031 Timeout: read to address with no responder, timeout_cycles=16 -> cyc/stb high exactly 16 cycles, tx byte 0x02 only, back to IDLE.
REQ-032 Error and priority: ack and err asserted same edge -> tx 0x01 only; junk bytes 00 FF 41 before 'R' command ignored, command executes normally.
REQ-033 Backpressure: tx_ready low 10 cycles during SEND -> tx_data/tx_valid stable, no byte lost or duplicated; rx_valid during BUS not consumed.
REQ-034 Reset mid-BUS: rst_n low while stb=1 -> cyc/stb 0 same cycle without clock edge; after release, new write completes correctly.

Source files
------------

// File: rtl/wb_dbg_master.sv
// -----------------------------------------------------------------------------
// wb_dbg_master
//
// Byte-stream debug bridge onto a Wishbone classic bus. A host sends either
//   'W' A3 A2 A1 A0 D3 D2 D1 D0   (single 32-bit write)
//   'R' A3 A2 A1 A0               (single 32-bit read)
// over a ready/valid byte channel. The bridge runs one Wishbone cycle and
// answers with a status byte (0x00 ok, 0x01 bus error, 0x02 timeout); a
// successful read is followed by the four data bytes, MSB first.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   rx_data/valid/ready     command bytes in
//   tx_data/valid/ready     response bytes out
//   wb_*                    Wishbone classic initiator (32-bit, full-word sel)
//
// Parameter
//   timeout_cycles          bus cycles to wait for ack/err before abort
// -----------------------------------------------------------------------------
module wb_dbg_master #(
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP, S_SEND
    } state_t;

    localparam logic [7:0]  CMD_WRITE  = 8'h57;
    localparam logic [7:0]  CMD_READ   = 8'h52;
    localparam logic [7:0]  ST_OK      = 8'h00;
    localparam logic [7:0]  ST_ERR     = 8'h01;
    localparam logic [7:0]  ST_TIMEOUT = 8'h02;
    // Counter value seen on the last permitted bus edge.
    localparam logic [15:0] TMO_LAST   = 16'(timeout_cycles - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_run;       // holds rx_ready low until the first edge after reset
    logic        r_is_write;
    logic [1:0]  r_cnt;       // byte index within ADDR/DATA/SEND, wraps to 0 at phase end
    logic [31:0] r_adr;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    logic [7:0]  r_status;
    logic [15:0] r_tmo;

    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_wdat;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and all handshake / bus strobes
    always_comb begin
        w_state_next = r_state;
        rx_ready     = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        wb_cyc_o     = 1'b0;
        wb_stb_o     = 1'b0;
        wb_we_o      = 1'b0;
        wb_sel_o     = 4'h0;
        case (r_state)
            S_IDLE: begin
                rx_ready = r_run;
                if (rx_valid && r_run &&
                    (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid && r_cnt == 2'd3) begin
                    w_state_next = r_is_write ? S_DATA : S_BUS;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && r_cnt == 2'd3) begin
                    w_state_next = S_BUS;
                end
            end
            S_BUS: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                wb_sel_o = 4'hF;
                wb_we_o  = r_is_write;
                // ack/err take priority over a timeout on the same edge
                if (wb_ack_i || wb_err_i || r_tmo == TMO_LAST) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                tx_valid = 1'b1;
                tx_data  = r_status;
                if (tx_ready) begin
                    w_state_next = (!r_is_write && r_status == ST_OK) ? S_SEND : S_IDLE;
                end
            end
            S_SEND: begin
                tx_valid = 1'b1;
                case (r_cnt)
                    2'd0:    tx_data = r_rdat[31:24];
                    2'd1:    tx_data = r_rdat[23:16];
                    2'd2:    tx_data = r_rdat[15:8];
                    default: tx_data = r_rdat[7:0];
                endcase
                if (tx_ready && r_cnt == 2'd3) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: shift registers, byte counter, timeout counter, status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_is_write <= 1'b0;
            r_cnt      <= 2'd0;
            r_adr      <= 32'h0;
            r_wdat     <= 32'h0;
            r_rdat     <= 32'h0;
            r_status   <= 8'h00;
            r_tmo      <= 16'h0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid && r_run) begin
                        if (rx_data == CMD_WRITE) begin
                            r_is_write <= 1'b1;
                        end else if (rx_data == CMD_READ) begin
                            r_is_write <= 1'b0;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        r_adr <= {r_adr[23:0], rx_data};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3 && !r_is_write) begin
                            r_tmo <= 16'h0;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_wdat <= {r_wdat[23:0], rx_data};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_tmo <= 16'h0;
                        end
                    end
                end
                S_BUS: begin
                    if (wb_err_i) begin
                        r_status <= ST_ERR;
                    end else if (wb_ack_i) begin
                        r_status <= ST_OK;
                        if (!r_is_write) begin
                            r_rdat <= wb_dat_i;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_status <= ST_TIMEOUT;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dbg_master.sv
// -----------------------------------------------------------------------------
// tb_wb_dbg_master
//
// Directed bench for wb_dbg_master with timeout_cycles = 16. Inputs are
// driven and outputs sampled on the falling clock edge; the DUT acts on the
// rising edge. The Wishbone slave is played inline by each scenario task.
// -----------------------------------------------------------------------------
module tb_wb_dbg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_dbg_master #(.timeout_cycles(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i)
    );

    // Offer one byte; returns at the falling edge after it was accepted.
    // ok is cleared if rx_ready never came.
    task automatic send_byte(input logic [7:0] b, inout bit ok);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) ok = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Take one response byte; got is cleared if tx_valid never came.
    task automatic recv_byte(output logic [7:0] b, output bit got);
        int n;
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        got = (tx_valid === 1'b1);
        b   = tx_data;
        @(negedge clk);
        tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        wb_dat_i = 32'h0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        #12;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b0) begin
            failures++;
            $display("FAIL reset_bus got cyc=%b stb=%b we=%b sel=%h want all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o);
        end
        checks++;
        if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_adr_dat got adr=%h dat=%h want 0", wb_adr_o, wb_dat_o);
        end
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_stream got tx_valid=%b tx_data=%h rx_ready=%b want 0",
                     tx_valid, tx_data, rx_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_rx_ready got %b want 0 before first edge", rx_ready);
        end
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_rx_ready_rise got %b want 1", rx_ready);
        end
        $display("reset: released, rx_ready=%b", rx_ready);
    endtask

    task automatic test_write;
        logic [7:0] cmd [9];
        logic [7:0] b;
        bit ok, got;
        cmd = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        ok = 1'b1;
        for (int i = 0; i < 9; i++) send_byte(cmd[i], ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_cmd_accept got rx_ready stuck low want accepted");
        end
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_bus_start got cyc=%b stb=%b rx_ready=%b want 1 1 0",
                     wb_cyc_o, wb_stb_o, rx_ready);
        end
        checks++;
        if (wb_adr_o !== 32'h10 || wb_dat_o !== 32'hDEADBEEF || wb_we_o !== 1'b1 || wb_sel_o !== 4'hF) begin
            failures++;
            $display("FAIL write_bus_fields got adr=%h dat=%h we=%b sel=%h want 00000010 deadbeef 1 f",
                     wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h10 || wb_dat_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_bus_hold got cyc=%b adr=%h dat=%h want 1 00000010 deadbeef",
                     wb_cyc_o, wb_adr_o, wb_dat_o);
        end
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL write_ack_resp got cyc=%b stb=%b tx_valid=%b tx_data=%h want 0 0 1 00",
                     wb_cyc_o, wb_stb_o, tx_valid, tx_data);
        end
        recv_byte(b, got);
        checks++;
        if (!got || b !== 8'h00) begin
            failures++;
            $display("FAIL write_status got=%b byte=%h want 1 00", got, b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_only_one_byte got tx_valid=%b rx_ready=%b want 0 1", tx_valid, rx_ready);
        end
        $display("write: adr=00000010 dat=deadbeef status=%h", b);
    endtask

    task automatic test_read;
        logic [7:0] cmd [5];
        logic [7:0] exp [5];
        logic [7:0] b;
        bit ok, got;
        cmd = '{8'h52, 8'hF0, 8'h00, 8'h00, 8'h04};
        exp = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        ok = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(cmd[i], ok);
        checks++;
        if (!ok || wb_cyc_o !== 1'b1 || wb_adr_o !== 32'hF0000004 || wb_we_o !== 1'b0 || wb_sel_o !== 4'hF) begin
            failures++;
            $display("FAIL read_bus_fields got ok=%b cyc=%b adr=%h we=%b sel=%h want 1 1 f0000004 0 f",
                     ok, wb_cyc_o, wb_adr_o, wb_we_o, wb_sel_o);
        end
        wb_dat_i = 32'h12345678;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            recv_byte(b, got);
            checks++;
            if (!got || b !== exp[i]) begin
                failures++;
                $display("FAIL read_byte%0d got=%b byte=%h want 1 %h", i, got, b, exp[i]);
            end
        end
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL read_end_idle got tx_valid=%b rx_ready=%b want 0 1", tx_valid, rx_ready);
        end
        $display("read: adr=f0000004 data=12345678");
    endtask

    task automatic test_timeout;
        logic [7:0] cmd [5];
        logic [7:0] b;
        bit ok, got;
        int n;
        cmd = '{8'h52, 8'h00, 8'h00, 8'h01, 8'h00};
        ok = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(cmd[i], ok);
        n = 0;
        while (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ok || n !== 16) begin
            failures++;
            $display("FAIL timeout_cycles got ok=%b high_cycles=%0d want 1 16", ok, n);
        end
        recv_byte(b, got);
        checks++;
        if (!got || b !== 8'h02) begin
            failures++;
            $display("FAIL timeout_status got=%b byte=%h want 1 02", got, b);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_idle got tx_valid=%b rx_ready=%b cyc=%b want 0 1 0",
                     tx_valid, rx_ready, wb_cyc_o);
        end
        $display("timeout: adr=00000100 cyc_cycles=%0d status=%h", n, b);
    endtask

    // ack arriving on the very edge the timeout would fire must win
    task automatic test_timeout_ack_edge;
        logic [7:0] cmd [5];
        logic [7:0] exp [5];
        logic [7:0] b;
        bit ok, got;
        cmd = '{8'h52, 8'h00, 8'h00, 8'h02, 8'h00};
        exp = '{8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        ok = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(cmd[i], ok);
        repeat (15) @(negedge clk);
        checks++;
        if (!ok || wb_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL ack_edge_still_busy got ok=%b cyc=%b want 1 1", ok, wb_cyc_o);
        end
        wb_dat_i = 32'hCAFEF00D;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            recv_byte(b, got);
            checks++;
            if (!got || b !== exp[i]) begin
                failures++;
                $display("FAIL ack_edge_byte%0d got=%b byte=%h want 1 %h", i, got, b, exp[i]);
            end
        end
        $display("read at timeout edge: adr=00000200 data=cafef00d");
    endtask

    task automatic test_err_priority;
        logic [7:0] junk [3];
        logic [7:0] cmd [5];
        logic [7:0] wcmd [9];
        logic [7:0] b;
        bit ok, got;
        junk = '{8'h00, 8'hFF, 8'h41};
        cmd  = '{8'h52, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        wcmd = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
        ok = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(junk[i], ok);
        checks++;
        if (!ok || rx_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL junk_ignored got ok=%b rx_ready=%b cyc=%b want 1 1 0", ok, rx_ready, wb_cyc_o);
        end
        for (int i = 0; i < 5; i++) send_byte(cmd[i], ok);
        checks++;
        if (!ok || wb_cyc_o !== 1'b1 || wb_adr_o !== 32'hA0B0C0D0 || wb_we_o !== 1'b0) begin
            failures++;
            $display("FAIL junk_then_read got ok=%b cyc=%b adr=%h we=%b want 1 1 a0b0c0d0 0",
                     ok, wb_cyc_o, wb_adr_o, wb_we_o);
        end
        wb_dat_i = 32'h55555555;
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        recv_byte(b, got);
        checks++;
        if (!got || b !== 8'h01) begin
            failures++;
            $display("FAIL err_priority_status got=%b byte=%h want 1 01", got, b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_only_one_byte got tx_valid=%b rx_ready=%b want 0 1", tx_valid, rx_ready);
        end
        $display("read with ack+err: adr=a0b0c0d0 status=%h", b);
        // plain error on a write
        for (int i = 0; i < 9; i++) send_byte(wcmd[i], ok);
        @(negedge clk);
        wb_err_i = 1'b1;
        @(negedge clk);
        wb_err_i = 1'b0;
        recv_byte(b, got);
        checks++;
        if (!ok || !got || b !== 8'h01) begin
            failures++;
            $display("FAIL err_write_status got ok=%b got=%b byte=%h want 1 1 01", ok, got, b);
        end
        $display("write with err: adr=00000020 status=%h", b);
    endtask

    task automatic test_backpressure;
        logic [7:0] cmd [5];
        logic [7:0] exp [4];
        logic [7:0] b;
        bit ok, got;
        cmd = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        ok = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(cmd[i], ok);
        rx_data  = 8'h57;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_ready !== 1'b0 || wb_cyc_o !== 1'b1) begin
                failures++;
                $display("FAIL bus_no_rx_accept cycle %0d got rx_ready=%b cyc=%b want 0 1", i, rx_ready, wb_cyc_o);
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        wb_dat_i = 32'hA1B2C3D4;
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        recv_byte(b, got);
        checks++;
        if (!ok || !got || b !== 8'h00) begin
            failures++;
            $display("FAIL bp_status got ok=%b got=%b byte=%h want 1 1 00", ok, got, b);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hA1) begin
                failures++;
                $display("FAIL bp_hold cycle %0d got tx_valid=%b tx_data=%h want 1 a1", i, tx_valid, tx_data);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            recv_byte(b, got);
            checks++;
            if (!got || b !== exp[i]) begin
                failures++;
                $display("FAIL bp_byte%0d got=%b byte=%h want 1 %h", i, got, b, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_end_idle got tx_valid=%b rx_ready=%b want 0 1", tx_valid, rx_ready);
        end
        $display("read with backpressure: adr=00000008 data=a1b2c3d4");
    endtask

    task automatic test_reset_mid_bus;
        logic [7:0] cmd1 [9];
        logic [7:0] cmd2 [9];
        logic [7:0] b;
        bit ok, got;
        int seen_tx;
        cmd1 = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h99};
        cmd2 = '{8'h57, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h01};
        ok = 1'b1;
        for (int i = 0; i < 9; i++) send_byte(cmd1[i], ok);
        @(negedge clk);
        checks++;
        if (!ok || wb_stb_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_bus_pre got ok=%b stb=%b want 1 1", ok, wb_stb_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_adr_o !== 32'h0 || rx_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_async_drop got cyc=%b stb=%b adr=%h rx_ready=%b want 0 0 0 0",
                     wb_cyc_o, wb_stb_o, wb_adr_o, rx_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_tx = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || wb_cyc_o !== 1'b0) seen_tx++;
        end
        checks++;
        if (seen_tx !== 0 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_no_response got active_cycles=%0d rx_ready=%b want 0 1", seen_tx, rx_ready);
        end
        for (int i = 0; i < 9; i++) send_byte(cmd2[i], ok);
        checks++;
        if (!ok || wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h12345678 || wb_dat_o !== 32'h1 || wb_we_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_new_write got ok=%b cyc=%b adr=%h dat=%h we=%b want 1 1 12345678 00000001 1",
                     ok, wb_cyc_o, wb_adr_o, wb_dat_o, wb_we_o);
        end
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        recv_byte(b, got);
        checks++;
        if (!got || b !== 8'h00) begin
            failures++;
            $display("FAIL rst_new_write_status got=%b byte=%h want 1 00", got, b);
        end
        $display("reset mid-bus then write: adr=12345678 dat=00000001 status=%h", b);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_timeout_ack_edge;
        test_err_priority;
        test_backpressure;
        test_reset_mid_bus;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
